seven_segment_scan_controller: RTL and testbench

Time-multiplexed scan controller for the 4-digit seven-segment display. It sequences the digit-select counter, inserts an anti-ghosting blank at every digit change, and applies PWM brightness. It decodes hex nibbles to segments and double-buffers display data with a frame-aligned load handshake. It sits between the application logic and the display pins, replacing a free-running digit counter.

---
 rtl/seven_segment_scan_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_seven_segment_scan_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_controller.sv
// -----------------------------------------------------------------------------
// seven_segment_scan_controller
//
// Time-multiplexed scan controller for a 4-digit, common-anode seven-segment
// display. Each digit owns a slot of DIV cycles. A slot starts with BLANK dark
// cycles (anti-ghosting), then lights the digit for SUB*(BRIGHT+1) cycles, then
// stays dark for the rest of the slot. Hex nibbles are decoded to active-low
// segments, with optional leading-zero suppression. Display data is double
// buffered: LOAD fills a pending buffer, which is copied to the active buffer
// only at the frame boundary, so a frame never mixes old and new data.
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   data_i      in   16  four hex nibbles, digit0 = data_i[3:0]
//   dp_i        in   4   decimal point per digit, 1 = lit
//   load_i      in   1   capture data_i/dp_i into the pending buffer
//   load_ack_o  out  1   one-cycle pulse after pending data became active
//   bright_i    in   3   duty level 0..7, sampled at slot cycle 0
//   lz_en_i     in   1   leading-zero suppression, sampled at slot cycle 0
//   s_clk_o     out  2   current digit index
//   an_o        out  4   anode select, active-low
//   seg_o       out  7   segments a..g on bits 0..6, active-low
//   dot_o       out  1   decimal point, active-low
//   frame_o     out  1   one-cycle pulse on the last cycle of the digit-3 slot
// -----------------------------------------------------------------------------
module seven_segment_scan_controller #(
    parameter int DIV   = 40000,
    parameter int BLANK = 400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_i,
    input  logic [3:0]  dp_i,
    input  logic        load_i,
    output logic        load_ack_o,
    input  logic [2:0]  bright_i,
    input  logic        lz_en_i,
    output logic [1:0]  s_clk_o,
    output logic [3:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dot_o,
    output logic        frame_o
);

    localparam int CW  = $clog2(DIV);
    localparam int SUB = (DIV - BLANK) / 8;

    localparam logic [1:0] ST_BLANK = 2'd0;
    localparam logic [1:0] ST_ON    = 2'd1;
    localparam logic [1:0] ST_OFF   = 2'd2;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    digit_q, digit_d;
    logic [1:0]    state_q, state_d;
    logic [2:0]    bright_q;
    logic          lz_q;
    logic [15:0]   act_data_q, act_data_d;
    logic [3:0]    act_dp_q, act_dp_d;
    logic [15:0]   pend_data_q, pend_data_d;
    logic [3:0]    pend_dp_q, pend_dp_d;
    logic          pend_q, pend_d;
    logic          ack_q, ack_d;
    logic          frame_q, frame_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dot_q, dot_d;

    // Working values for the combinational block.
    logic          slot_end;
    logic [2:0]    bright_use;
    logic          lz_use;
    int            on_end;
    logic [15:0]   upper;
    logic          supp;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    // Output registers are computed from the *next* counter/digit/buffer values,
    // so each registered output lines up with the slot cycle shown in cnt_q.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        cnt_d       = cnt_q;
        digit_d     = digit_q;
        state_d     = state_q;
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pend_d      = pend_q;
        ack_d       = 1'b0;
        an_d        = 4'b1111;
        seg_d       = 7'h7F;
        dot_d       = 1'b1;

        slot_end = (cnt_q == CW'(DIV - 1));
        if (slot_end) begin
            cnt_d   = '0;
            digit_d = digit_q + 2'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        frame_d = (cnt_d == CW'(DIV - 1)) && (digit_d == 2'd3);

        // Brightness and suppression follow the inputs during slot cycle 0 and
        // are held for the rest of the slot. With BLANK = 0, cycle 0 is already
        // lit, so the value present on the edge into cycle 0 is used there.
        bright_use = (cnt_q == '0 || cnt_d == '0) ? bright_i : bright_q;
        lz_use     = (cnt_q == '0 || cnt_d == '0) ? lz_en_i  : lz_q;
        on_end     = BLANK + SUB * (int'(bright_use) + 1);

        // Slot FSM. When on_end reaches DIV the ON->OFF compare never matches,
        // so OFF is skipped at full brightness.
        if (cnt_d == '0) begin
            state_d = (BLANK > 0) ? ST_BLANK : ST_ON;
        end else begin
            case (state_q)
                ST_BLANK: if (int'(cnt_d) == BLANK)  state_d = ST_ON;
                ST_ON:    if (int'(cnt_d) == on_end) state_d = ST_OFF;
                default:  state_d = ST_OFF;
            endcase
        end

        // Frame boundary: a LOAD on the FRAME cycle itself wins over pending data.
        if (frame_q && (pend_q || load_i)) begin
            act_data_d = load_i ? data_i : pend_data_q;
            act_dp_d   = load_i ? dp_i   : pend_dp_q;
            pend_d     = 1'b0;
            ack_d      = 1'b1;
        end else if (load_i) begin
            pend_data_d = data_i;
            pend_dp_d   = dp_i;
            pend_d      = 1'b1;
        end

        // A digit is a leading zero when it and every higher nibble are zero.
        upper = act_data_d >> {digit_d, 2'b00};
        supp  = lz_use && (digit_d != 2'd0) && (upper == 16'h0000);

        if (state_d == ST_ON) begin
            if (supp) begin
                // Suppressed digit still shows its decimal point if set.
                if (act_dp_d[digit_d]) begin
                    an_d  = ~(4'b0001 << digit_d);
                    dot_d = 1'b0;
                end
            end else begin
                an_d  = ~(4'b0001 << digit_d);
                seg_d = decode(upper[3:0]);
                dot_d = ~act_dp_d[digit_d];
            end
        end
    end

    // NOTE: the data buffers are ordinary flops and take the reset too, so a
    // reset discards pending data and blanks the display to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            digit_q     <= 2'd0;
            state_q     <= ST_BLANK;
            bright_q    <= 3'd0;
            lz_q        <= 1'b0;
            act_data_q  <= 16'h0000;
            act_dp_q    <= 4'h0;
            pend_data_q <= 16'h0000;
            pend_dp_q   <= 4'h0;
            pend_q      <= 1'b0;
            ack_q       <= 1'b0;
            frame_q     <= 1'b0;
            an_q        <= 4'b1111;
            seg_q       <= 7'h7F;
            dot_q       <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            cnt_q       <= cnt_d;
            digit_q     <= digit_d;
            state_q     <= state_d;
            bright_q    <= bright_use;
            lz_q        <= lz_use;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            pend_q      <= pend_d;
            ack_q       <= ack_d;
            frame_q     <= frame_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dot_q       <= dot_d;
        end
    end

    assign s_clk_o    = digit_q;
    assign an_o       = an_q;
    assign seg_o      = seg_q;
    assign dot_o      = dot_q;
    assign frame_o    = frame_q;
    assign load_ack_o = ack_q;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// -----------------------------------------------------------------------------
// Directed bench for seven_segment_scan_controller with DIV = 20, BLANK = 4
// (SUB = 2). cyc counts cycles since the last reset release; the slot cycle is
// cyc % 20 and the digit is (cyc / 20) % 4. Inputs change and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_seven_segment_scan_controller;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_i;
    logic [3:0]  dp_i;
    logic        load_i;
    logic        load_ack_o;
    logic [2:0]  bright_i;
    logic        lz_en_i;
    logic [1:0]  s_clk_o;
    logic [3:0]  an_o;
    logic [6:0]  seg_o;
    logic        dot_o;
    logic        frame_o;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    seven_segment_scan_controller #(.DIV(20), .BLANK(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_i     (data_i),
        .dp_i       (dp_i),
        .load_i     (load_i),
        .load_ack_o (load_ack_o),
        .bright_i   (bright_i),
        .lz_en_i    (lz_en_i),
        .s_clk_o    (s_clk_o),
        .an_o       (an_o),
        .seg_o      (seg_o),
        .dot_o      (dot_o),
        .frame_o    (frame_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto(input int t);
        while (cyc < t) tick();
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
        data_i = d;
        dp_i   = p;
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        data_i   = 16'h0000;
        dp_i     = 4'h0;
        load_i   = 1'b0;
        bright_i = 3'd7;
        lz_en_i  = 1'b0;
        repeat (3) @(negedge clk);
        check("por_an",  16'(an_o),  16'hF);
        check("por_seg", 16'(seg_o), 16'h7F);
        rst_n = 1'b1;
        cyc   = 0;

        // Mid-slot reset held 5 cycles.
        goto(10);
        rst_n = 1'b0;
        #1;
        check("rst_an",    16'(an_o),       16'hF);
        check("rst_seg",   16'(seg_o),      16'h7F);
        check("rst_dot",   16'(dot_o),      16'h1);
        check("rst_sclk",  16'(s_clk_o),    16'h0);
        check("rst_frame", 16'(frame_o),    16'h0);
        check("rst_ack",   16'(load_ack_o), 16'h0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        check("rel_an",   16'(an_o),    16'hF);
        check("rel_sclk", 16'(s_clk_o), 16'h0);

        // Scan sequence with zero data at full brightness.
        goto(3);  check("d0_blank_an", 16'(an_o), 16'hF);
        goto(4);  check("d0_on_an",    16'(an_o), 16'hE);
                  check("d0_on_seg",   16'(seg_o), 16'h40);
        goto(19); check("d0_end_an",   16'(an_o), 16'hE);
        goto(20); check("sclk_1",      16'(s_clk_o), 16'h1);
                  check("slot1_c0_an", 16'(an_o), 16'hF);
        goto(40); check("sclk_2",      16'(s_clk_o), 16'h2);
        goto(60); check("sclk_3",      16'(s_clk_o), 16'h3);
        goto(78); check("frame_pre",   16'(frame_o), 16'h0);
        goto(79); check("frame_0",     16'(frame_o), 16'h1);
        goto(80); check("sclk_wrap",   16'(s_clk_o), 16'h0);
                  check("frame_post",  16'(frame_o), 16'h0);
                  check("no_ack_idle", 16'(load_ack_o), 16'h0);

        // Single LOAD of 1234 in frame 1.
        goto(90);  pulse_load(16'h1234, 4'h0);
        goto(91);  check("ack_not_early", 16'(load_ack_o), 16'h0);
        goto(159); check("frame_1",       16'(frame_o), 16'h1);
                   check("ack_on_frame",  16'(load_ack_o), 16'h0);
        goto(160); check("ack_pulse",     16'(load_ack_o), 16'h1);
                   check("f2_c0_an",      16'(an_o), 16'hF);
        goto(161); check("ack_one_cycle", 16'(load_ack_o), 16'h0);
        goto(163); check("f2_d0_blank",   16'(an_o), 16'hF);
        goto(164); check("f2_d0_an",      16'(an_o), 16'hE);
                   check("f2_d0_seg",     16'(seg_o), 16'h19);
                   check("f2_d0_dot",     16'(dot_o), 16'h1);
        goto(179); check("f2_d0_end_seg", 16'(seg_o), 16'h19);
        goto(224); check("f2_d3_an",      16'(an_o), 16'h7);
                   check("f2_d3_seg",     16'(seg_o), 16'h79);

        // Brightness: 0 takes effect next slot, 3 mid-slot holds old duty.
        goto(230); bright_i = 3'd0;
        goto(238); check("bright7_held", 16'(an_o), 16'h7);
        goto(243); check("b0_blank",     16'(an_o), 16'hF);
        goto(245); check("b0_on_last",   16'(an_o), 16'hE);
        goto(246); check("b0_off",       16'(an_o), 16'hF);
        goto(250); bright_i = 3'd3;
        goto(251); check("b0_held",      16'(an_o), 16'hF);
        goto(264); check("b3_on_first",  16'(an_o), 16'hD);
        goto(271); check("b3_on_last",   16'(an_o), 16'hD);
                   check("b3_seg",       16'(seg_o), 16'h30);
        goto(272); check("b3_off",       16'(an_o), 16'hF);
        goto(275); bright_i = 3'd7;

        // Leading-zero suppression with 00A5, DP on digit 2.
        goto(290); lz_en_i = 1'b1; pulse_load(16'h00A5, 4'b0100);
        goto(320); check("lz_ack",     16'(load_ack_o), 16'h1);
        goto(324); check("lz_d0_an",   16'(an_o), 16'hE);
                   check("lz_d0_seg",  16'(seg_o), 16'h12);
        goto(344); check("lz_d1_an",   16'(an_o), 16'hD);
                   check("lz_d1_seg",  16'(seg_o), 16'h08);
        goto(364); check("lz_d2_an",   16'(an_o), 16'hB);
                   check("lz_d2_seg",  16'(seg_o), 16'h7F);
                   check("lz_d2_dot",  16'(dot_o), 16'h0);
        goto(384); check("lz_d3_an",   16'(an_o), 16'hF);
                   check("lz_d3_dot",  16'(dot_o), 16'h1);
        goto(399); check("lz_d3_end",  16'(an_o), 16'hF);

        // Two LOADs in one frame: latest wins, single ACK.
        goto(410); pulse_load(16'h1111, 4'h0);
        goto(420); pulse_load(16'h2222, 4'h0);
        goto(421); check("dbl_no_ack",   16'(load_ack_o), 16'h0);
        goto(480); check("dbl_ack",      16'(load_ack_o), 16'h1);
        goto(481); check("dbl_ack_once", 16'(load_ack_o), 16'h0);
        goto(484); check("dbl_d0_seg",   16'(seg_o), 16'h24);
        goto(544); check("dbl_d3_an",    16'(an_o), 16'h7);
                   check("dbl_d3_seg",   16'(seg_o), 16'h24);

        // LOAD on the FRAME cycle is applied at that boundary.
        goto(559); check("fl_frame", 16'(frame_o), 16'h1);
                   pulse_load(16'h5678, 4'h0);
        goto(560); check("fl_ack",    16'(load_ack_o), 16'h1);
        goto(564); check("fl_d0_seg", 16'(seg_o), 16'h00);

        // Reset with a LOAD pending: display returns to zero, no ACK.
        goto(570); pulse_load(16'hFFFF, 4'hF);
        goto(585); check("pend_d0... ", 16'(s_clk_o), 16'h1);
        goto(605);
        rst_n = 1'b0;
        #1;
        check("rp_an",  16'(an_o),       16'hF);
        check("rp_ack", 16'(load_ack_o), 16'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        goto(44); check("rp_d2_an",    16'(an_o), 16'hF);
        goto(64); check("rp_d3_an",    16'(an_o), 16'hF);
        goto(79); check("rp_frame",    16'(frame_o), 16'h1);
        goto(80); check("rp_no_ack",   16'(load_ack_o), 16'h0);
        goto(84); check("rp_d0_an",    16'(an_o), 16'hE);
                  check("rp_d0_seg",   16'(seg_o), 16'h40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
